hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller that drives the stall and flush inputs of the PC, the IF/ID register and the ID/EX register (`Flush` = load-use bubble, `Flush2` = control-transfer kill). It sits beside the ID stage. It compares the ID-stage source registers against the EX-stage load destination and sequences multi-cycle load-use stalls with a small FSM. It also resolves flush priority between taken branches (EX), jumps (ID) and stalls, and keeps saturating stall and flush event counters for debug.

## Interface
- `LOAD_LAT`, default 1: load-use stall cycles inserted per hazard; legal range 1..7.
- `CNT_W`, default 32: width of the debug counters.

- `Clk`  in  1  pipeline clock, rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Rs_ID`, `Rt_ID`  in  5 each  source register numbers of the instruction in ID.
- `UsesRs_ID`, `UsesRt_ID`  in  1 each  ID instruction actually reads Rs / Rt.
- `MemRead_EX`  in  1  instruction in EX is a load.
- `DestReg_EX`  in  5  write register of the EX instruction, already RegDst-muxed.
- `BranchTaken_EX`  in  1  branch in EX resolved taken.
- `Jump_ID`  in  1  j/jal/jr is in ID and its target is valid this cycle.
- `PCWrite`  out  1  PC update enable.
- `IF_ID_Write`  out  1  IF/ID load enable.
- `IF_ID_Flush`  out  1  zero IF/ID at the next edge.
- `Flush`  out  1  to ID/EX: insert a bubble (load-use).
- `Flush2`  out  1  to ID/EX: kill the ID instruction (taken branch).
- `StallCount`  out  CNT_W  cycles with `PCWrite`=0; saturating.
- `FlushCount`  out  CNT_W  cycles with `Flush2`=1 or `IF_ID_Flush`=1; saturating.

## Operation
- Hazard term `lu` = MemRead_EX & (DestReg_EX≠0) & ((UsesRs_ID & DestReg_EX==Rs_ID) | (UsesRt_ID & DestReg_EX==Rt_ID)).
- FSM states:
  - RUN: normal operation.
  - LU_STALL: the ID instruction is held while the load completes.
- 3-bit down-counter `rem` runs alongside the FSM.
- RUN outputs, evaluated in strict priority order:
  1. BranchTaken_EX: `Flush2`=1, `IF_ID_Flush`=1, `PCWrite`=1, `IF_ID_Write`=1. `lu` and Jump_ID are ignored.
  2. else `lu`: `PCWrite`=0, `IF_ID_Write`=0, `Flush`=1, `IF_ID_Flush`=0. If LOAD_LAT>1, go to LU_STALL with `rem`=LOAD_LAT-1.
  3. else Jump_ID: `IF_ID_Flush`=1, `PCWrite`=1, `IF_ID_Write`=1.
  4. else all enables 1, all flushes 0.
- LU_STALL: `PCWrite`=0, `IF_ID_Write`=0, `Flush`=1.
  - `rem` decrements each cycle; leave for RUN on the cycle `rem`==1.
  - Jump_ID is ignored (jr may depend on the load).
  - BranchTaken_EX cannot legally occur here because EX holds a bubble. If it is asserted anyway, branch behaviour from RUN applies, `Flush` is deasserted, and the FSM returns to RUN with `rem`=0.
- All outputs except the counters are combinational from state, `rem` and inputs.
- `Flush` and `Flush2` are never both 1.
- Counters: each increments by 1 on the edge ending a qualifying cycle and holds at 2^CNT_W−1.

## Timing
- Hazard response has zero latency: `Flush`/stall are asserted in the same cycle `lu` is true, so they are sampled at the next edge.
- The ID instruction is held for exactly LOAD_LAT cycles per hazard.
- Reset (asynchronous, Reset_n=0): state RUN, `rem`=0, both counters 0 immediately.
- With quiet inputs during reset: `PCWrite`=1, `IF_ID_Write`=1, `IF_ID_Flush`=0, `Flush`=0, `Flush2`=0.
- Reset asserted mid-stall aborts the stall on the same cycle.
- Deassertion is sampled synchronously; the first active edge behaves as RUN.
- Back-to-back loads: a new `lu` on the cycle after leaving LU_STALL restarts a full stall.

## Structure
- Shared pipeline package holds the state encoding `HZ_RUN`/`HZ_LU_STALL` and the register-zero constant `REG_ZERO` = 5'd0.
- One natural sub-module: `sat_counter` (parameter width, increment enable, synchronous saturation), instantiated twice.

## Test plan
- Load x in EX (MemRead_EX=1, DestReg_EX=8) with Rs_ID=8, UsesRs_ID=1, LOAD_LAT=1 → one cycle of `Flush`=1, `PCWrite`=0, `IF_ID_Write`=0; back to RUN next cycle; StallCount=1.
- Same stimulus with LOAD_LAT=3 → stall held exactly 3 cycles; no extra cycle on exit; StallCount=3.
- DestReg_EX=0 with Rs_ID=0, or match on Rt with UsesRt_ID=0 → no stall; all enables 1.
- BranchTaken_EX=1 together with Jump_ID=1 and a load-use match → `Flush2`=1, `IF_ID_Flush`=1, `Flush`=0, `PCWrite`=1; FlushCount+1.
- Jump_ID=1 during LU_STALL → `IF_ID_Flush` stays 0 until the stall ends. On the first RUN cycle with Jump_ID still 1 → `IF_ID_Flush`=1.
- Reset_n pulsed low in cycle 2 of a LOAD_LAT=3 stall → outputs return to RUN values immediately; both counters read 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM encoding, register-zero
// constant and the load-use match helper.
package hazard_ctrl_pkg;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_LU_STALL = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         REM_W    = 3;

  // A load to $0 never produces a real value, so it can never cause a hazard.
  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] dest,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rs,
    input logic       uses_rt
  );
    return mem_read && (dest != REG_ZERO) &&
           ((uses_rs && (dest == rs)) || (uses_rt && (dest == rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments on enable and sticks at its all-ones value.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall sequencing and branch/jump flush arbitration for the
// PC, IF/ID and ID/EX registers, with saturating debug counters.
module hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UsesRs_ID,
  input  logic             UsesRt_ID,
  input  logic             MemRead_EX,
  input  logic [4:0]       DestReg_EX,
  input  logic             BranchTaken_EX,
  input  logic             Jump_ID,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             Flush,
  output logic             Flush2,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  import hazard_ctrl_pkg::*;

  localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_LAT - 1);

  hz_state_t        state, state_next;
  logic [REM_W-1:0] rem, rem_next;
  logic             lu;

  assign lu = load_use(MemRead_EX, DestReg_EX, Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= HZ_RUN;
      rem   <= '0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
    end
  end

  // The first stall cycle is spent in RUN, so LU_STALL covers LOAD_LAT-1 more.
  always_comb begin
    state_next = state;
    rem_next   = rem;
    case (state)
      HZ_RUN: begin
        if (BranchTaken_EX) begin
          state_next = HZ_RUN;
          rem_next   = '0;
        end else if (lu && (LOAD_LAT > 1)) begin
          state_next = HZ_LU_STALL;
          rem_next   = REM_INIT;
        end
      end
      HZ_LU_STALL: begin
        if (BranchTaken_EX || (rem == REM_W'(1))) begin
          state_next = HZ_RUN;
          rem_next   = '0;
        end else begin
          rem_next = rem - REM_W'(1);
        end
      end
      default: begin
        state_next = HZ_RUN;
        rem_next   = '0;
      end
    endcase
  end

  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    Flush       = 1'b0;
    Flush2      = 1'b0;
    if (BranchTaken_EX) begin
      IF_ID_Flush = 1'b1;
      Flush2      = 1'b1;
    end else if ((state == HZ_LU_STALL) || lu) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      Flush       = 1'b1;
    end else if (Jump_ID) begin
      // A jr may be waiting on the load, so jumps only count once back in RUN.
      IF_ID_Flush = 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .en    (!PCWrite),
    .count (StallCount)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .en    (Flush2 || IF_ID_Flush),
    .count (FlushCount)
  );

endmodule
